// File: rtl/nios2_oci_dct_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nios2_oci_dct_pkg
//  Brief    : Shared constants and types for the OCI DCT trace packer.
//  Revision : 1.0  initial release
// ============================================================================
package nios2_oci_dct_pkg;

    localparam int ATOM_W  = 2;
    localparam int SLOTS   = 15;
    localparam int BUF_W   = ATOM_W * SLOTS;
    localparam int CNT_W   = 4;
    localparam int STALL_W = 16;

    localparam logic [CNT_W-1:0] SLOTS_CNT = CNT_W'(SLOTS);

    localparam logic GRANT_ITRACE = 1'b0;
    localparam logic GRANT_DTRACE = 1'b1;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EMIT    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_ENDED   = 2'd3
    } dct_state_e;

    typedef enum logic [ATOM_W-1:0] {
        ATOM_NONE      = 2'b00,
        ATOM_TAKEN     = 2'b01,
        ATOM_NOT_TAKEN = 2'b10,
        ATOM_SYNC      = 2'b11
    } dct_atom_e;

endpackage
`default_nettype wire

// File: rtl/nios2_oci_dct_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : nios2_oci_dct_rr_arb
//  Brief    : Two-way round-robin arbiter; grant[0]=itrace, grant[1]=dtrace.
//  Revision : 1.0  initial release
// ============================================================================
module nios2_oci_dct_rr_arb
    import nios2_oci_dct_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid_i,
    input  logic       i_valid_d,
    input  logic       i_enable,
    input  logic       i_advance,
    output logic [1:0] o_grant,
    output logic       o_last_grant
);

    logic r_last;
    logic w_pick_d;
    logic w_pick_i;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        w_pick_d = i_valid_d && (!i_valid_i || (r_last == GRANT_ITRACE));
        w_pick_i = i_valid_i && !w_pick_d;
        o_grant  = i_enable ? {w_pick_d, w_pick_i} : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= GRANT_DTRACE;
        end else if (i_advance && (o_grant != 2'b00)) begin
            r_last <= o_grant[1];
        end
    end

    assign o_last_grant = r_last;

endmodule
`default_nettype wire

// File: rtl/nios2_oci_dct_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nios2_oci_dct_ctrl
//  Brief    : Packs itrace/dtrace atoms into 15-slot DCT packets and
//             sequences end-of-test draining.
//  Revision : 1.0  initial release
// ============================================================================
module nios2_oci_dct_ctrl
    import nios2_oci_dct_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               trace_enable,
    input  logic               itrace_valid,
    input  logic [ATOM_W-1:0]  itrace_atom,
    output logic               itrace_ready,
    input  logic               dtrace_valid,
    input  logic [ATOM_W-1:0]  dtrace_atom,
    output logic               dtrace_ready,
    input  logic               flush_req,
    input  logic               end_req,
    output logic               pkt_valid,
    output logic [BUF_W-1:0]   pkt_data,
    output logic [CNT_W-1:0]   pkt_count,
    input  logic               pkt_ready,
    output logic [BUF_W-1:0]   dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               test_ending,
    output logic               test_has_ended,
    output logic [STALL_W-1:0] stall_cycles
);

    dct_state_e         r_state;
    dct_state_e         w_state_nxt;
    logic [BUF_W-1:0]   r_buffer;
    logic [BUF_W-1:0]   w_buffer_ins;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_inc;
    logic               r_end_latched;
    logic [STALL_W-1:0] r_stall;
    logic [BUF_W-1:0]   r_dct_buffer;
    logic [CNT_W-1:0]   r_dct_count;
    logic               w_accept_ok;
    logic [1:0]         w_grant;
    logic               w_accepting;
    logic [ATOM_W-1:0]  w_atom;
    logic               w_handshake;
    logic               w_unused_last_grant;

    assign w_accept_ok = (r_state == ST_COLLECT) && trace_enable && !end_req
                         && (r_count < SLOTS_CNT);

    nios2_oci_dct_rr_arb u_arb (
        .clk          (clk),
        .rst          (reset),
        .i_valid_i    (itrace_valid),
        .i_valid_d    (dtrace_valid),
        .i_enable     (w_accept_ok),
        .i_advance    (w_accepting),
        .o_grant      (w_grant),
        .o_last_grant (w_unused_last_grant)
    );

    assign itrace_ready = w_grant[0];
    assign dtrace_ready = w_grant[1];
    assign w_accepting  = |w_grant;
    assign w_atom       = w_grant[1] ? dtrace_atom : itrace_atom;
    assign w_count_inc  = r_count + 1'b1;
    assign pkt_valid    = (r_state == ST_EMIT) || (r_state == ST_DRAIN);
    assign w_handshake  = pkt_valid && pkt_ready;

    // Drop the granted atom into the slot selected by the current count.
    always_comb begin
        w_buffer_ins = r_buffer;
        for (int s = 0; s < SLOTS; s++) begin
            if (CNT_W'(s) == r_count) begin
                w_buffer_ins[s*ATOM_W +: ATOM_W] = w_atom;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_COLLECT: begin
                if (end_req && ((r_count != '0) || w_accepting)) begin
                    w_state_nxt = ST_DRAIN;
                end else if (end_req) begin
                    w_state_nxt = ST_ENDED;
                end else if (w_accepting && (w_count_inc == SLOTS_CNT)) begin
                    w_state_nxt = ST_EMIT;
                end else if (flush_req && ((r_count != '0) || w_accepting)) begin
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (w_handshake) begin
                    w_state_nxt = (r_end_latched || end_req) ? ST_ENDED : ST_COLLECT;
                end
            end
            ST_DRAIN: begin
                if (w_handshake) begin
                    w_state_nxt = ST_ENDED;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buffer      <= '0;
            r_count       <= '0;
            r_end_latched <= 1'b0;
            r_stall       <= '0;
            r_dct_buffer  <= '0;
            r_dct_count   <= '0;
        end else begin
            r_dct_buffer <= r_buffer;
            r_dct_count  <= r_count;
            if (w_accepting) begin
                r_buffer <= w_buffer_ins;
                r_count  <= w_count_inc;
            end else if (w_handshake) begin
                r_buffer <= '0;
                r_count  <= '0;
            end
            if ((r_state == ST_EMIT) && end_req) begin
                r_end_latched <= 1'b1;
            end
            if (pkt_valid && !pkt_ready && (r_stall != '1)) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign pkt_data       = r_buffer;
    assign pkt_count      = r_count;
    assign dct_buffer     = r_dct_buffer;
    assign dct_count      = r_dct_count;
    assign test_ending    = (r_state == ST_DRAIN);
    assign test_has_ended = (r_state == ST_ENDED);
    assign stall_cycles   = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_nios2_oci_dct_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nios2_oci_dct_ctrl
//  Brief    : Directed and random stimulus against a queue-based packet model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nios2_oci_dct_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_enable;
    logic        itrace_valid;
    logic [1:0]  itrace_atom;
    logic        itrace_ready;
    logic        dtrace_valid;
    logic [1:0]  dtrace_atom;
    logic        dtrace_ready;
    logic        flush_req;
    logic        end_req;
    logic        pkt_valid;
    logic [29:0] pkt_data;
    logic [3:0]  pkt_count;
    logic        pkt_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
    logic [15:0] stall_cycles;

    always #5 clk = ~clk;

    nios2_oci_dct_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .trace_enable   (trace_enable),
        .itrace_valid   (itrace_valid),
        .itrace_atom    (itrace_atom),
        .itrace_ready   (itrace_ready),
        .dtrace_valid   (dtrace_valid),
        .dtrace_atom    (dtrace_atom),
        .dtrace_ready   (dtrace_ready),
        .flush_req      (flush_req),
        .end_req        (end_req),
        .pkt_valid      (pkt_valid),
        .pkt_data       (pkt_data),
        .pkt_count      (pkt_count),
        .pkt_ready      (pkt_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .stall_cycles   (stall_cycles)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: mode 0 collect, 1 emit, 2 drain, 3 ended.
    int          m_mode;
    logic [1:0]  m_q[$];
    bit          m_last_d;
    bit          m_endlat;
    int          m_stall;
    logic [29:0] m_dct_buf;
    int          m_dct_cnt;

    function automatic logic [29:0] pack_q();
        logic [29:0] r;
        r = '0;
        foreach (m_q[i]) r[2*i +: 2] = m_q[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_q.delete();
        m_last_d  = 1'b1;
        m_endlat  = 1'b0;
        m_stall   = 0;
        m_dct_buf = '0;
        m_dct_cnt = 0;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        trace_enable = 1'b0;
        itrace_valid = 1'b0;
        itrace_atom  = 2'b00;
        dtrace_valid = 1'b0;
        dtrace_atom  = 2'b00;
        flush_req    = 1'b0;
        end_req      = 1'b0;
        pkt_ready    = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic cycle(input bit en, input bit iv, input logic [1:0] ia,
                         input bit dv, input logic [1:0] da,
                         input bit fl, input bit er, input bit pr);
        bit aok, gi, gd, pv;
        trace_enable = en;
        itrace_valid = iv;
        itrace_atom  = ia;
        dtrace_valid = dv;
        dtrace_atom  = da;
        flush_req    = fl;
        end_req      = er;
        pkt_ready    = pr;
        #1;
        aok = (m_mode == 0) && en && !er && (m_q.size() < 15);
        gi  = aok && iv && (!dv || m_last_d);
        gd  = aok && dv && (!iv || !m_last_d);
        pv  = (m_mode == 1) || (m_mode == 2);
        chk("itrace_ready", 32'(itrace_ready), 32'(gi));
        chk("dtrace_ready", 32'(dtrace_ready), 32'(gd));
        chk("pkt_valid", 32'(pkt_valid), 32'(pv));
        if (pv) begin
            chk("pkt_data", 32'(pkt_data), 32'(pack_q()));
            chk("pkt_count", 32'(pkt_count), 32'(m_q.size()));
        end
        chk("test_ending", 32'(test_ending), 32'(m_mode == 2));
        chk("test_has_ended", 32'(test_has_ended), 32'(m_mode == 3));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        chk("dct_buffer", 32'(dct_buffer), 32'(m_dct_buf));
        chk("dct_count", 32'(dct_count), 32'(m_dct_cnt));
        @(posedge clk);
        m_dct_buf = pack_q();
        m_dct_cnt = m_q.size();
        if (pv && !pr && m_stall < 65535) m_stall++;
        case (m_mode)
            0: begin
                if (gi) begin m_q.push_back(ia); m_last_d = 1'b0; end
                if (gd) begin m_q.push_back(da); m_last_d = 1'b1; end
                if (er)                          m_mode = (m_q.size() > 0) ? 2 : 3;
                else if ((gi || gd) && m_q.size() == 15) m_mode = 1;
                else if (fl && m_q.size() > 0)   m_mode = 1;
            end
            1: begin
                if (er) m_endlat = 1'b1;
                if (pr) begin m_q.delete(); m_mode = m_endlat ? 3 : 0; end
            end
            2: if (pr) begin m_q.delete(); m_mode = 3; end
            default: ;
        endcase
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Fill a full packet from itrace.
        for (int i = 0; i < 15; i++) cycle(1, 1, 2'b01, 0, 2'b00, 0, 0, 1);
        chk("fill_valid", 32'(pkt_valid), 32'd1);
        chk("fill_data", 32'(pkt_data), 32'h1555_5555);
        chk("fill_count", 32'(pkt_count), 32'd15);
        cycle(1, 0, 2'b00, 0, 2'b00, 0, 0, 1);
        chk("fill_count_cleared", 32'(pkt_count), 32'd0);

        // Round-robin with both requesters active.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 1, 2'b01, 1, 2'b10, 0, 0, 1);
        cycle(1, 0, 2'b00, 0, 2'b00, 0, 0, 1);
        chk("rr_dct_low_byte", 32'(dct_buffer[7:0]), 32'h99);
        cycle(1, 0, 2'b00, 0, 2'b00, 1, 0, 1);
        cycle(1, 0, 2'b00, 0, 2'b00, 0, 0, 1);

        // Flush of a partial packet, then an empty flush.
        for (int i = 0; i < 3; i++) cycle(1, 1, 2'b11, 0, 2'b00, 0, 0, 0);
        cycle(1, 0, 2'b00, 0, 2'b00, 1, 0, 0);
        chk("flush_count", 32'(pkt_count), 32'd3);
        chk("flush_data", 32'(pkt_data), 32'h3F);
        cycle(1, 0, 2'b00, 0, 2'b00, 0, 0, 1);
        cycle(1, 0, 2'b00, 0, 2'b00, 1, 0, 1);
        chk("empty_flush_no_pkt", 32'(pkt_valid), 32'd0);

        // Backpressure on a full packet.
        do_reset();
        for (int i = 0; i < 15; i++)
            cycle(1, 1, 2'($urandom), 1, 2'($urandom), 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 1, 2'b01, 1, 2'b10, 0, 0, 0);
        chk("bp_stall_cycles", 32'(stall_cycles), 32'd10);
        cycle(1, 1, 2'b01, 1, 2'b10, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 2'b01, 1, 2'b10, 0, 0, 1);

        // End of test with a partial buffer.
        do_reset();
        for (int i = 0; i < 5; i++)
            cycle(1, 1, 2'($urandom), 1, 2'($urandom), 0, 0, 0);
        cycle(1, 1, 2'b01, 1, 2'b10, 0, 1, 0);
        chk("end_test_ending", 32'(test_ending), 32'd1);
        chk("end_drain_count", 32'(pkt_count), 32'd5);
        cycle(1, 1, 2'b01, 1, 2'b10, 0, 0, 1);
        chk("end_has_ended", 32'(test_has_ended), 32'd1);
        for (int i = 0; i < 5; i++) cycle(1, 1, 2'b01, 1, 2'b10, i[0], 0, 1);
        chk("end_sticky", 32'(test_has_ended), 32'd1);

        // Reset in the middle of EMIT.
        do_reset();
        for (int i = 0; i < 15; i++) cycle(1, 1, 2'b10, 0, 2'b00, 0, 0, 0);
        chk("pre_reset_valid", 32'(pkt_valid), 32'd1);
        do_reset();
        #1;
        chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_has_ended", 32'(test_has_ended), 32'd0);
        chk("rst_stall", 32'(stall_cycles), 32'd0);
        chk("rst_dct_count", 32'(dct_count), 32'd0);
        cycle(1, 1, 2'b01, 1, 2'b10, 0, 0, 1);
        cycle(1, 1, 2'b01, 1, 2'b10, 0, 0, 1);

        // Random traffic checked cycle by cycle against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (m_mode == 3 && ($urandom % 8) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom % 10) != 0, 1'($urandom), 2'($urandom),
                      1'($urandom), 2'($urandom), ($urandom % 16) == 0,
                      ($urandom % 150) == 0, ($urandom % 10) < 7);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
